// File: rtl/iop_mem_arb_if.sv
// Port bundle for iop_mem_arb: IOP data ports, host CPU port, shared memory port and error flag.
interface iop_mem_arb_if;
  logic [20:0] iop_raddr;
  logic [20:0] iop_waddr;
  logic [7:0]  iop_wdata;
  logic        iop_rd;
  logic        iop_wr;
  logic [7:0]  iop_rdata;
  logic        iop_rwait;
  logic        iop_wwait;

  logic [20:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_rd;
  logic        host_wr;
  logic [7:0]  host_rdata;
  logic        host_wait;

  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_rdy;

  logic        arb_err;
  logic        arb_err_clr;

  modport slave (
    input  iop_raddr, iop_waddr, iop_wdata, iop_rd, iop_wr,
    input  host_addr, host_wdata, host_rd, host_wr,
    input  mem_rdata, mem_rdy, arb_err_clr,
    output iop_rdata, iop_rwait, iop_wwait, host_rdata, host_wait,
    output mem_addr, mem_wdata, mem_rd, mem_wr, arb_err
  );

  modport master (
    output iop_raddr, iop_waddr, iop_wdata, iop_rd, iop_wr,
    output host_addr, host_wdata, host_rd, host_wr,
    output mem_rdata, mem_rdy, arb_err_clr,
    input  iop_rdata, iop_rwait, iop_wwait, host_rdata, host_wait,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, arb_err
  );
endinterface

// File: rtl/iop_mem_arb.sv
// Round-robin arbiter sharing one byte-wide memory port between the IOP408 and the host CPU.
// Define IOP_ARB_TIMEOUT_EN to add the access watchdog and sticky arb_err flag.
module iop_mem_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           sysclk,
  input logic           sysrst,
  iop_mem_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, G_IOP = 2'd1, G_HOST = 2'd2} state_t;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] iop_hold, host_hold;
  logic       iop_req, host_req;
  logic       iop_do_wr, iop_do_rd, host_do_wr, host_do_rd;
  logic       gnt_iop, gnt_host, granted;
  logic       timeout_hit, done;
  logic       iop_rd_done, host_rd_done;
  logic [7:0] rd_data;

  // A requester asserting both strobes has its write served first.
  assign iop_req    = bus.iop_rd | bus.iop_wr;
  assign host_req   = bus.host_rd | bus.host_wr;
  assign iop_do_wr  = bus.iop_wr;
  assign iop_do_rd  = bus.iop_rd & ~bus.iop_wr;
  assign host_do_wr = bus.host_wr;
  assign host_do_rd = bus.host_rd & ~bus.host_wr;

  assign gnt_iop  = (state == G_IOP) & iop_req;
  assign gnt_host = (state == G_HOST) & host_req;
  assign granted  = gnt_iop | gnt_host;
  assign done     = granted & (bus.mem_rdy | timeout_hit);
  assign rd_data  = timeout_hit ? 8'hFF : bus.mem_rdata;

  assign iop_rd_done  = done & gnt_iop & iop_do_rd;
  assign host_rd_done = done & gnt_host & host_do_rd;

  assign bus.iop_rdata  = iop_rd_done ? rd_data : iop_hold;
  assign bus.host_rdata = host_rd_done ? rd_data : host_hold;
  assign bus.iop_wwait  = bus.iop_wr & ~(done & gnt_iop & iop_do_wr);
  assign bus.iop_rwait  = bus.iop_rd & ~iop_rd_done;
  assign bus.host_wait  = host_req & ~(done & gnt_host);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    if (gnt_iop) begin
      bus.mem_addr  = iop_do_wr ? bus.iop_waddr : bus.iop_raddr;
      bus.mem_wdata = bus.iop_wdata;
      bus.mem_rd    = iop_do_rd;
      bus.mem_wr    = iop_do_wr;
    end else if (gnt_host) begin
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.mem_rd    = host_do_rd;
      bus.mem_wr    = host_do_wr;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (iop_req && host_req) state_nxt = last ? G_IOP : G_HOST;
        else if (iop_req)        state_nxt = G_IOP;
        else if (host_req)       state_nxt = G_HOST;
      end
      G_IOP: begin
        // A dropped strobe abandons the access without moving the priority pointer.
        if (!iop_req) begin
          state_nxt = IDLE;
        end else if (done) begin
          last_nxt = 1'b0;
          if (host_req)                    state_nxt = G_HOST;
          else if (iop_do_wr && bus.iop_rd) state_nxt = G_IOP;
          else                             state_nxt = IDLE;
        end
      end
      G_HOST: begin
        if (!host_req) begin
          state_nxt = IDLE;
        end else if (done) begin
          last_nxt  = 1'b1;
          state_nxt = iop_req ? G_IOP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!sysrst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge sysclk) begin
    // NOTE: the read-hold registers are reset because rdata is observable straight out of reset.
    if (!sysrst) begin
      iop_hold  <= 8'h00;
      host_hold <= 8'h00;
    end else begin
      if (iop_rd_done)  iop_hold  <= rd_data;
      if (host_rd_done) host_hold <= rd_data;
    end
  end

`ifdef IOP_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err;

  always_ff @(posedge sysclk) begin
    if (!sysrst || !granted || done) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 8'd1;
  end

  assign timeout_hit = granted & ~bus.mem_rdy & (wd_cnt == 8'(TIMEOUT));

  // A timeout in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge sysclk) begin
    if (!sysrst)              err <= 1'b0;
    else if (timeout_hit)     err <= 1'b1;
    else if (bus.arb_err_clr) err <= 1'b0;
  end

  assign bus.arb_err = err;
`else
  logic unused_cfg;
  assign unused_cfg  = bus.arb_err_clr ^ TIMEOUT[0];
  assign timeout_hit = 1'b0;
  assign bus.arb_err = 1'b0;
`endif
endmodule

// File: tb/tb_iop_mem_arb.sv
// Self-checking bench for iop_mem_arb: cycle model compared every cycle plus directed literal checks.
module tb_iop_mem_arb;
  localparam int TMO = 4;

  logic sysclk = 1'b0;
  logic sysrst;
  iop_mem_arb_if bus();

  iop_mem_arb #(.TIMEOUT(TMO)) dut (
    .sysclk (sysclk),
    .sysrst (sysrst),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner;      // 0 none, 1 IOP, 2 host
  bit         m_last_host;
  int         m_wait;
  logic [7:0] m_iop_hold, m_host_hold;
  bit         m_err;

  logic [20:0] e_addr;
  logic [7:0]  e_wdata, e_data, e_irdata, e_hrdata;
  logic        e_rd, e_wr, e_rwait, e_wwait, e_hwait;
  bit          e_fin, e_forced, s_iop, s_host;

  function automatic int pick(bit i, bit h, bit lh);
    if (i && h) return lh ? 1 : 2;
    if (i) return 1;
    if (h) return 2;
    return 0;
  endfunction

  task automatic model_eval();
    bit ireq, hreq;
    ireq = bus.iop_rd || bus.iop_wr;
    hreq = bus.host_rd || bus.host_wr;
    s_iop  = (m_owner == 1) && ireq;
    s_host = (m_owner == 2) && hreq;
    e_addr = '0; e_wdata = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (s_iop) begin
      e_wr = bus.iop_wr;
      e_rd = bus.iop_rd && !bus.iop_wr;
      e_addr = bus.iop_wr ? bus.iop_waddr : bus.iop_raddr;
      e_wdata = bus.iop_wdata;
    end else if (s_host) begin
      e_wr = bus.host_wr;
      e_rd = bus.host_rd && !bus.host_wr;
      e_addr = bus.host_addr;
      e_wdata = bus.host_wdata;
    end
    e_forced = 1'b0;
`ifdef IOP_ARB_TIMEOUT_EN
    e_forced = (s_iop || s_host) && !bus.mem_rdy && (m_wait == TMO);
`endif
    e_fin    = (s_iop || s_host) && (bus.mem_rdy || e_forced);
    e_data   = e_forced ? 8'hFF : bus.mem_rdata;
    e_irdata = (e_fin && s_iop && e_rd) ? e_data : m_iop_hold;
    e_hrdata = (e_fin && s_host && e_rd) ? e_data : m_host_hold;
    e_wwait  = bus.iop_wr && !(e_fin && s_iop);
    e_rwait  = bus.iop_rd && !(e_fin && s_iop && !bus.iop_wr);
    e_hwait  = hreq && !(e_fin && s_host);
  endtask

  task automatic model_step();
    bit ireq, hreq;
    model_eval();
    ireq = bus.iop_rd || bus.iop_wr;
    hreq = bus.host_rd || bus.host_wr;
    if (!sysrst) begin
      m_owner = 0; m_last_host = 1'b1; m_wait = 0;
      m_iop_hold = 8'h00; m_host_hold = 8'h00; m_err = 1'b0;
    end else begin
      if (e_fin) begin
        if (s_iop && e_rd)  m_iop_hold  = e_data;
        if (s_host && e_rd) m_host_hold = e_data;
      end
      if (e_forced) m_err = 1'b1;
      else if (bus.arb_err_clr) m_err = 1'b0;
      m_wait = (e_fin || !(s_iop || s_host)) ? 0 : m_wait + 1;
      if (m_owner == 0) m_owner = pick(ireq, hreq, m_last_host);
      else if (!(s_iop || s_host)) m_owner = 0;
      else if (e_fin) begin
        m_last_host = s_host;
        if (s_iop) m_owner = hreq ? 2 : ((bus.iop_wr && bus.iop_rd) ? 1 : 0);
        else       m_owner = ireq ? 1 : 0;
      end
    end
  endtask

  initial begin : compare
    @(posedge sysclk);
    model_step();
    forever begin
      @(negedge sysclk);
      model_eval();
      check("cmp_mem", {bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata}, {e_wr, e_rd, e_addr, e_wdata});
      check("cmp_wait", {bus.iop_wwait, bus.iop_rwait, bus.host_wait}, {e_wwait, e_rwait, e_hwait});
      check("cmp_rdata", {bus.iop_rdata, bus.host_rdata}, {e_irdata, e_hrdata});
      check("cmp_err", bus.arb_err, m_err);
      @(posedge sysclk);
      model_step();
    end
  end

  // ---------------- stimulus: masters and memory responder ----------------
  int lat = 0;
  int age = 0;
  logic [7:0] rd_val = 8'h00;
  int iop_rd_n = 0, iop_wr_n = 0, host_rd_n = 0, host_wr_n = 0;

  typedef struct {int cyc; int kind; logic [20:0] addr;} ev_t;  // kind: 0 IOP wr, 1 IOP rd, 2 host
  ev_t log_q[$];

  function automatic ev_t ev(int i);
    ev_t z = '{-1, -1, '0};
    if (i < log_q.size()) return log_q[i];
    return z;
  endfunction

  task automatic raise();
    bus.iop_rd  = iop_rd_n > 0;
    bus.iop_wr  = iop_wr_n > 0;
    bus.host_rd = host_rd_n > 0;
    bus.host_wr = host_wr_n > 0;
  endtask

  task automatic tick();
    bit c_iw, c_ir, c_h;
    @(negedge sysclk);
    c_iw = bus.iop_wr && !bus.iop_wwait;
    c_ir = bus.iop_rd && !bus.iop_rwait;
    c_h  = (bus.host_rd || bus.host_wr) && !bus.host_wait;
    if (c_iw) log_q.push_back('{cyc, 0, bus.mem_addr});
    if (c_ir) log_q.push_back('{cyc, 1, bus.mem_addr});
    if (c_h)  log_q.push_back('{cyc, 2, bus.mem_addr});
    age = (c_iw || c_ir || c_h || !(bus.mem_rd || bus.mem_wr)) ? 0 : age + 1;
    @(posedge sysclk);
    #1;
    cyc++;
    if (c_iw && iop_wr_n > 0) iop_wr_n--;
    if (c_ir && iop_rd_n > 0) iop_rd_n--;
    if (c_h && bus.host_wr && host_wr_n > 0) host_wr_n--;
    else if (c_h && host_rd_n > 0) host_rd_n--;
    raise();
    #1;
    bus.mem_rdata = rd_val;
    bus.mem_rdy   = (bus.mem_rd || bus.mem_wr) && (age >= lat);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((iop_rd_n + iop_wr_n + host_rd_n + host_wr_n) != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, iop_rd_n + iop_wr_n + host_rd_n + host_wr_n, 0);
  endtask

  int s;

  initial begin : stim
    sysrst = 1'b0;
    bus.iop_raddr = '0; bus.iop_waddr = '0; bus.iop_wdata = '0;
    bus.iop_rd = 1'b0; bus.iop_wr = 1'b0;
    bus.host_addr = '0; bus.host_wdata = '0; bus.host_rd = 1'b0; bus.host_wr = 1'b0;
    bus.mem_rdata = '0; bus.mem_rdy = 1'b0; bus.arb_err_clr = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_mem", {bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata}, 0);
    check("rst_rdata", {bus.iop_rdata, bus.host_rdata}, 16'h0000);
    check("rst_err", bus.arb_err, 0);
    bus.host_rd = 1'b1;
    #1 check("rst_hwait", bus.host_wait, 1);
    bus.host_rd = 1'b0;
    sysrst = 1'b1;
    tick();

    // IOP read, memory ready on the fourth granted cycle
    log_q.delete();
    lat = 3; rd_val = 8'hA5; bus.iop_raddr = 21'h012345;
    iop_rd_n = 1; raise(); s = cyc;
    wait_idle("t1_done", 20);
    check("t1_addr", ev(0).addr, 21'h012345);
    check("t1_lat", ev(0).cyc - s, 4);
    rd_val = 8'h3C; tick(); tick();
    check("t1_hold", bus.iop_rdata, 8'hA5);

    // Simultaneous writes after reset: IOP first, host with no gap
    sysrst = 1'b0; tick(); sysrst = 1'b1; tick();
    log_q.delete();
    lat = 0;
    bus.iop_waddr = 21'h000100; bus.iop_wdata = 8'h11;
    bus.host_addr = 21'h1ABCDE; bus.host_wdata = 8'h22;
    iop_wr_n = 1; host_wr_n = 1; raise(); s = cyc;
    wait_idle("t2_done", 20);
    check("t2_first", {ev(0).kind, ev(0).cyc - s}, {32'd0, 32'd1});
    check("t2_second", {ev(1).kind, ev(1).cyc - s, ev(1).addr}, {32'd2, 32'd2, 21'h1ABCDE});

    // Four back-to-back contended accesses alternate
    log_q.delete();
    iop_wr_n = 2; host_wr_n = 2; raise(); s = cyc;
    wait_idle("t3_done", 30);
    for (int i = 0; i < 4; i++)
      check("t3_order", {ev(i).kind, ev(i).cyc - s}, {((i % 2) == 0) ? 32'd0 : 32'd2, 32'(i + 1)});

    // IOP read+write together: write to 0x10, then read from 0x20
    log_q.delete();
    lat = 1; rd_val = 8'h77;
    bus.iop_waddr = 21'h000010; bus.iop_raddr = 21'h000020;
    iop_wr_n = 1; iop_rd_n = 1; raise(); s = cyc;
    wait_idle("t4_done", 20);
    check("t4_wr", {ev(0).kind, ev(0).cyc - s, ev(0).addr}, {32'd0, 32'd2, 21'h000010});
    check("t4_rd", {ev(1).kind, ev(1).cyc - s, ev(1).addr}, {32'd1, 32'd4, 21'h000020});
    check("t4_rdata", bus.iop_rdata, 8'h77);

    // Host drops its strobe mid-grant
    lat = 100; bus.host_addr = 21'h0ABCDE;
    host_rd_n = 1; raise();
    tick(); tick();
    check("t5_granted", {bus.mem_rd, bus.mem_addr}, {1'b1, 21'h0ABCDE});
    host_rd_n = 0; raise();
    tick();
    check("t5_dropped", {bus.mem_wr, bus.mem_rd, bus.mem_addr}, 0);

    // Pointer unchanged by the abandoned access: host still wins the tie
    log_q.delete();
    lat = 0;
    iop_wr_n = 1; host_wr_n = 1; raise(); s = cyc;
    wait_idle("t6_done", 20);
    check("t6_order", {ev(0).kind, ev(1).kind}, {32'd2, 32'd0});

    // Reset in the middle of an access at the top address
    lat = 100; bus.iop_raddr = 21'h1FFFFF;
    iop_rd_n = 1; raise();
    tick(); tick();
    check("t7_active", {bus.mem_rd, bus.mem_addr}, {1'b1, 21'h1FFFFF});
    sysrst = 1'b0;
    tick();
    check("t7_reset", {bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata}, 0);
    iop_rd_n = 0; raise();
    sysrst = 1'b1;
    tick();

    // Host read that the memory never acknowledges
    log_q.delete();
    rd_val = 8'h5A; bus.host_addr = 21'h000055;
`ifdef IOP_ARB_TIMEOUT_EN
    lat = 1000;
`else
    lat = 2;
`endif
    host_rd_n = 1; raise(); s = cyc;
    wait_idle("t8_done", 30);
`ifdef IOP_ARB_TIMEOUT_EN
    check("t8_lat", ev(0).cyc - s, TMO + 1);
    check("t8_rdata", bus.host_rdata, 8'hFF);
    check("t8_err", bus.arb_err, 1);
`else
    check("t8_lat", ev(0).cyc - s, 3);
    check("t8_rdata", bus.host_rdata, 8'h5A);
    check("t8_err", bus.arb_err, 0);
`endif
    bus.arb_err_clr = 1'b1;
    tick();
    bus.arb_err_clr = 1'b0;
    check("t8_clr", bus.arb_err, 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
